// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among N_REQ requesters.
// Optional macro RF_WR_BYPASS_EN forwards the registered write onto the read ports.
module regfile_write_arbiter #(
  parameter int N_REQ = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [5*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 wr_hold,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [2:0]           grant_id,
  output logic [CNT_W-1:0]     conflict_cnt,
  input  logic [4:0]           rd_addr1,
  input  logic [4:0]           rd_addr2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  output logic [31:0]          rd_data1,
  output logic [31:0]          rd_data2
);

  logic [2:0]       ptr_q, ptr_d;
  logic             rfWe_q, rfWe_d;
  logic [4:0]       rfWaddr_q, rfWaddr_d;
  logic [31:0]      rfWdata_q, rfWdata_d;
  logic [2:0]       grantId_q, grantId_d;
  logic [CNT_W-1:0] conflictCnt_q, conflictCnt_d;

  logic             grantFound;
  logic [2:0]       grantIdx;
  logic [4:0]       selAddr;
  logic [31:0]      selData;

  // Scan from the pointer, wrapping, and take the first valid requester.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grantFound && req_valid[i] && (((int'(ptr_q) + k) % N_REQ) == i)) begin
          grantFound = 1'b1;
          grantIdx   = 3'(i);
        end
      end
    end
    if (rst || wr_hold) begin
      grantFound = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    selAddr   = '0;
    selData   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantIdx == 3'(i)) begin
        req_ready[i] = grantFound;
        selAddr      = req_addr[i*5 +: 5];
        selData      = req_data[i*32 +: 32];
      end
    end
  end

  // Writes to r0 are accepted and latched but never raise the write enable.
  always_comb begin
    ptr_d         = ptr_q;
    rfWe_d        = 1'b0;
    rfWaddr_d     = rfWaddr_q;
    rfWdata_d     = rfWdata_q;
    grantId_d     = grantId_q;
    conflictCnt_d = conflictCnt_q;
    if (grantFound) begin
      rfWe_d    = (selAddr != 5'd0);
      rfWaddr_d = selAddr;
      rfWdata_d = selData;
      grantId_d = grantIdx;
      ptr_d     = (grantIdx == 3'(N_REQ - 1)) ? 3'd0 : grantIdx + 3'd1;
      if (($countones(req_valid) >= 2) && (conflictCnt_q != {CNT_W{1'b1}})) begin
        conflictCnt_d = conflictCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      rfWe_q        <= 1'b0;
      rfWaddr_q     <= '0;
      rfWdata_q     <= '0;
      grantId_q     <= '0;
      conflictCnt_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      rfWe_q        <= rfWe_d;
      rfWaddr_q     <= rfWaddr_d;
      rfWdata_q     <= rfWdata_d;
      grantId_q     <= grantId_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign rf_we        = rfWe_q;
  assign rf_waddr     = rfWaddr_q;
  assign rf_wdata     = rfWdata_q;
  assign grant_id     = grantId_q;
  assign conflict_cnt = conflictCnt_q;

`ifdef RF_WR_BYPASS_EN
  assign rd_data1 = (rfWe_q && (rd_addr1 == rfWaddr_q) && (rd_addr1 != 5'd0)) ? rfWdata_q : rf_rdata1;
  assign rd_data2 = (rfWe_q && (rd_addr2 == rfWaddr_q) && (rd_addr2 != 5'd0)) ? rfWdata_q : rf_rdata2;
`else
  // Read addresses only matter when forwarding is built in.
  logic unusedRdAddr;
  assign unusedRdAddr = ^{rd_addr1, rd_addr2};
  assign rd_data1 = rf_rdata1;
  assign rd_data2 = rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: table-driven single-cycle vectors plus
// hand-written reset, round-robin, hold, forwarding and saturation sequences.
module tb_regfile_write_arbiter;

  localparam int N_REQ = 3;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_REQ-1:0]  req_valid = '0;
  logic [14:0]       req_addr = '0;
  logic [95:0]       req_data = '0;
  logic [N_REQ-1:0]  req_ready;
  logic              wr_hold = 1'b0;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic [2:0]        grant_id;
  logic [CNT_W-1:0]  conflict_cnt;
  logic [4:0]        rd_addr1 = '0;
  logic [4:0]        rd_addr2 = '0;
  logic [31:0]       rf_rdata1 = '0;
  logic [31:0]       rf_rdata2 = '0;
  logic [31:0]       rd_data1;
  logic [31:0]       rd_data2;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_hold(wr_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .grant_id(grant_id), .conflict_cnt(conflict_cnt),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       valid;
    logic [14:0]      addr;
    logic [95:0]      data;
    logic             hold;
    logic [2:0]       expReady;
    logic             expWe;
    logic [4:0]       expWaddr;
    logic [31:0]      expWdata;
    logic [2:0]       expGid;
    logic [CNT_W-1:0] expCnt;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mkVec(logic [2:0] v, logic [14:0] a, logic [95:0] d, logic h,
                                 logic [2:0] r, logic we, logic [4:0] wa, logic [31:0] wd,
                                 logic [2:0] g, logic [CNT_W-1:0] c);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.hold = h; t.expReady = r;
    t.expWe = we; t.expWaddr = wa; t.expWdata = wd; t.expGid = g; t.expCnt = c;
    return t;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    wr_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one vector, check the combinational grant, then the registered write a cycle later.
  task automatic applyStimulus(vec_t v, int idx);
    @(negedge clk);
    req_valid = v.valid;
    req_addr  = v.addr;
    req_data  = v.data;
    wr_hold   = v.hold;
    #1;
    checkOutput($sformatf("vec%0d ready", idx), 64'(req_ready), 64'(v.expReady));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d rf_we", idx), 64'(rf_we), 64'(v.expWe));
    checkOutput($sformatf("vec%0d rf_waddr", idx), 64'(rf_waddr), 64'(v.expWaddr));
    checkOutput($sformatf("vec%0d rf_wdata", idx), 64'(rf_wdata), 64'(v.expWdata));
    checkOutput($sformatf("vec%0d grant_id", idx), 64'(grant_id), 64'(v.expGid));
    checkOutput($sformatf("vec%0d conflict_cnt", idx), 64'(conflict_cnt), 64'(v.expCnt));
  endtask

  initial begin
    logic [31:0] expRd;

    // Table starts from reset: pointer 0, counter 0.
    vecs[0]  = mkVec(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0,
                     3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 3'd1, 4'd0);
    vecs[1]  = mkVec(3'b000, 15'd0, 96'd0, 1'b0,
                     3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 3'd1, 4'd0);
    vecs[2]  = mkVec(3'b011, {5'd0, 5'd4, 5'd3}, {32'h0, 32'h22222222, 32'h11111111}, 1'b0,
                     3'b001, 1'b1, 5'd3, 32'h11111111, 3'd0, 4'd1);
    vecs[3]  = mkVec(3'b011, {5'd0, 5'd4, 5'd3}, {32'h0, 32'h22222222, 32'h11111111}, 1'b0,
                     3'b010, 1'b1, 5'd4, 32'h22222222, 3'd1, 4'd2);
    vecs[4]  = mkVec(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 1'b0,
                     3'b001, 1'b0, 5'd0, 32'h1234, 3'd0, 4'd2);
    vecs[5]  = mkVec(3'b101, {5'd10, 5'd0, 5'd9}, {32'hAA, 32'h0, 32'h99}, 1'b0,
                     3'b100, 1'b1, 5'd10, 32'hAA, 3'd2, 4'd3);
    vecs[6]  = mkVec(3'b101, {5'd10, 5'd0, 5'd9}, {32'hAA, 32'h0, 32'h99}, 1'b1,
                     3'b000, 1'b0, 5'd10, 32'hAA, 3'd2, 4'd3);
    vecs[7]  = mkVec(3'b101, {5'd10, 5'd0, 5'd9}, {32'hAA, 32'h0, 32'h99}, 1'b0,
                     3'b001, 1'b1, 5'd9, 32'h99, 3'd0, 4'd4);
    vecs[8]  = mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0,
                     3'b010, 1'b1, 5'd2, 32'hB, 3'd1, 4'd5);
    vecs[9]  = mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0,
                     3'b100, 1'b1, 5'd3, 32'hC, 3'd2, 4'd6);
    vecs[10] = mkVec(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0,
                     3'b001, 1'b1, 5'd1, 32'hA, 3'd0, 4'd7);

    // Reset with requests pending: ready must stay low and state clear.
    rst = 1'b1;
    req_valid = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready", 64'(req_ready), 64'd0);
    checkOutput("reset rf_we", 64'(rf_we), 64'd0);
    checkOutput("reset rf_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("reset rf_wdata", 64'(rf_wdata), 64'd0);
    checkOutput("reset grant_id", 64'(grant_id), 64'd0);
    checkOutput("reset conflict_cnt", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("idle ready", 64'(req_ready), 64'd0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], i);
    end

    // All three requesters held valid: strict rotation 0,1,2,0,1,2.
    doReset();
    req_addr = {5'd13, 5'd12, 5'd11};
    req_data = {32'h3333, 32'h2222, 32'h1111};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput($sformatf("rr ready %0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
      @(posedge clk);
      #1;
      checkOutput($sformatf("rr grant_id %0d", k), 64'(grant_id), 64'(k % 3));
      checkOutput($sformatf("rr rf_waddr %0d", k), 64'(rf_waddr), 64'(11 + (k % 3)));
      @(negedge clk);
    end
    req_valid = '0;
    @(posedge clk);
    #1;
    checkOutput("rr conflict_cnt", 64'(conflict_cnt), 64'd6);
    checkOutput("rr idle rf_we", 64'(rf_we), 64'd0);

    // Hold for three cycles, then release: requester 0 wins from pointer 0.
    doReset();
    req_addr = {5'd20, 5'd0, 5'd21};
    req_data = {32'h20, 32'h0, 32'h21};
    req_valid = 3'b101;
    wr_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("hold ready %0d", k), 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold rf_we %0d", k), 64'(rf_we), 64'd0);
      checkOutput($sformatf("hold cnt %0d", k), 64'(conflict_cnt), 64'd0);
      @(negedge clk);
    end
    wr_hold = 1'b0;
    #1;
    checkOutput("release ready", 64'(req_ready), 64'(3'b001));
    @(posedge clk);
    #1;
    checkOutput("release grant_id", 64'(grant_id), 64'd0);
    checkOutput("release cnt", 64'(conflict_cnt), 64'd1);

    // Read-port forwarding against a live write to r7.
    @(negedge clk);
    req_valid = 3'b010;
    req_addr = {5'd0, 5'd7, 5'd0};
    req_data = {32'h0, 32'hA5A5A5A5, 32'h0};
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rd_addr1 = 5'd7;
    rf_rdata1 = 32'h0;
    rd_addr2 = 5'd7;
    rf_rdata2 = 32'h77;
    #1;
    checkOutput("bypass write live", 64'(rf_we), 64'd1);
`ifdef RF_WR_BYPASS_EN
    expRd = 32'hA5A5A5A5;
`else
    expRd = 32'h0;
`endif
    checkOutput("rd_data1 hit", 64'(rd_data1), 64'(expRd));
`ifdef RF_WR_BYPASS_EN
    expRd = 32'hA5A5A5A5;
`else
    expRd = 32'h77;
`endif
    checkOutput("rd_data2 hit", 64'(rd_data2), 64'(expRd));
    rd_addr1 = 5'd0;
    rf_rdata1 = 32'h5555;
    #1;
    checkOutput("rd_data1 r0", 64'(rd_data1), 64'h5555);

    // Reset asserted right after an accept cancels the pending write enable.
    @(negedge clk);
    req_valid = 3'b001;
    req_addr = {5'd0, 5'd0, 5'd8};
    req_data = {32'h0, 32'h0, 32'h88};
    @(posedge clk);
    #1;
    checkOutput("pre-rst rf_we", 64'(rf_we), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid-rst rf_we", 64'(rf_we), 64'd0);
    checkOutput("mid-rst rf_waddr", 64'(rf_waddr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;

    // Counter saturates at all-ones instead of wrapping.
    doReset();
    req_valid = 3'b011;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("saturated cnt", 64'(conflict_cnt), 64'hF);
    @(negedge clk);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
